// File: rtl/uart_sniff_pkg.sv
// rtl/uart_sniff_pkg.sv - shared types, defaults and helpers for the UART sniffer receive stage
package uart_sniff_pkg;

   localparam int DEF_CLKS_PER_BIT = 434;
   localparam int DEF_FIFO_DEPTH   = 8;
   localparam int DATA_W           = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   // Occupancy must represent 0..depth inclusive, hence depth+1 codes.
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/uart_sniff_rx_if.sv
// rtl/uart_sniff_rx_if.sv - valid/ready byte stream carrying received characters
interface uart_sniff_rx_if;
   import uart_sniff_pkg::*;

   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/uart_sniff_fifo.sv
// rtl/uart_sniff_fifo.sv - synchronous byte FIFO with push/pop/full/empty/level
module uart_sniff_fifo
   import uart_sniff_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = DATA_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             wr_en;
   logic             rd_en;

   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign full     = (count == LW'(DEPTH));
   assign empty    = (count == '0);
   assign rd_en    = pop & ~empty;
   assign wr_en    = push & (~full | rd_en);
   assign level    = count;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_sniff_rx.sv
// rtl/uart_sniff_rx.sv - 8N1 UART deframer with byte FIFO and sticky errors; UART_SNIFF_PARITY_EN selects 8E1
module uart_sniff_rx
   import uart_sniff_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input  logic                               io_clock,
   input  logic                               io_reset,
   input  logic                               io_rxd,
   uart_sniff_rx_if.master                    m_if,
   output logic [level_width(FIFO_DEPTH)-1:0] o_level,
   output logic                               o_frame_err,
   output logic                               o_parity_err,
   output logic                               o_overflow,
   input  logic                               i_clear
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t         state;
   logic [CW-1:0]     cnt;
   logic [2:0]        bit_idx;
   logic [DATA_W-1:0] shreg;
   logic              rx_meta;
   logic              rxs;
   logic              at_last;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              frame_ev;
   logic              ovf_ev;

   // Two-flop synchronizer; resets to the idle-high line level.
   always_ff @(posedge io_clock or negedge io_reset) begin
      if (!io_reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= io_rxd;
         rxs     <= rx_meta;
      end
   end

   assign at_last  = (cnt == CNT_LAST);
   assign frame_ev = (state == STOP) && at_last && !rxs;
`ifdef UART_SNIFF_PARITY_EN
   logic par_bad;
   logic par_ev;
   assign par_ev = (state == PARITY) && at_last && (rxs != ^shreg);
   assign push   = (state == STOP) && at_last && rxs && !par_bad;
`else
   assign push   = (state == STOP) && at_last && rxs;
`endif
   assign pop    = !fifo_empty && m_if.m_ready;
   assign ovf_ev = push && fifo_full && !pop;

   // Frame deserializer: half-bit start qualification, then one sample per bit time.
   always_ff @(posedge io_clock or negedge io_reset) begin
      if (!io_reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_SNIFF_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
`ifdef UART_SNIFF_PARITY_EN
               par_bad <= 1'b0;
`endif
               if (!rxs) state <= START;
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt   <= '0;
                  state <= rxs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (at_last) begin
                  cnt     <= '0;
                  shreg   <= {rxs, shreg[DATA_W-1:1]};
                  bit_idx <= bit_idx + 1'b1;
`ifdef UART_SNIFF_PARITY_EN
                  if (bit_idx == 3'd7) state <= PARITY;
`else
                  if (bit_idx == 3'd7) state <= STOP;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_SNIFF_PARITY_EN
            PARITY: begin
               if (at_last) begin
                  cnt     <= '0;
                  par_bad <= par_ev;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (at_last) begin
                  cnt   <= '0;
                  state <= rxs ? IDLE : BREAK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               cnt <= '0;
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky error flags; a new event wins over a coincident clear.
   always_ff @(posedge io_clock or negedge io_reset) begin
      if (!io_reset) begin
         o_frame_err <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         o_frame_err <= (o_frame_err & ~i_clear) | frame_ev;
         o_overflow  <= (o_overflow & ~i_clear) | ovf_ev;
      end
   end

`ifdef UART_SNIFF_PARITY_EN
   // Sticky parity flag, same clear priority as the other flags.
   always_ff @(posedge io_clock or negedge io_reset) begin
      if (!io_reset) o_parity_err <= 1'b0;
      else           o_parity_err <= (o_parity_err & ~i_clear) | par_ev;
   end
`else
   assign o_parity_err = 1'b0;
`endif

   assign m_if.m_valid = !fifo_empty;

   uart_sniff_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (io_clock),
      .rst_n     (io_reset),
      .push      (push),
      .push_data (shreg),
      .pop       (pop),
      .pop_data  (m_if.m_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (o_level)
   );

endmodule

// File: tb/tb_uart_sniff_rx.sv
// tb/tb_uart_sniff_rx.sv - directed self-checking bench for uart_sniff_rx
module tb_uart_sniff_rx;
   import uart_sniff_pkg::*;

   localparam int CPB   = 434;
   localparam int DEPTH = 8;
`ifdef UART_SNIFF_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // Negedges from the cycle the line drops until m_valid is seen:
   // 2 sync + 1 IDLE->START, half bit to start sample, then one bit per remaining sample.
   localparam int FIRST_VALID = 4 + CPB / 2 + CPB * (FRAME_BITS - 1);

   logic       io_clock = 1'b0;
   logic       io_reset = 1'b0;
   logic       io_rxd   = 1'b1;
   logic       i_clear  = 1'b0;
   logic [3:0] o_level;
   logic       o_frame_err;
   logic       o_parity_err;
   logic       o_overflow;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] rx_q[$];
`ifdef UART_SNIFF_PARITY_EN
   logic bad_par = 1'b0;
`endif

   uart_sniff_rx_if u_if ();

   uart_sniff_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .io_clock     (io_clock),
      .io_reset     (io_reset),
      .io_rxd       (io_rxd),
      .m_if         (u_if),
      .o_level      (o_level),
      .o_frame_err  (o_frame_err),
      .o_parity_err (o_parity_err),
      .o_overflow   (o_overflow),
      .i_clear      (i_clear)
   );

   always #5 io_clock = ~io_clock;

   // Record every accepted beat, sampled half a cycle before the accepting edge.
   always @(negedge io_clock) begin
      if (io_reset && u_if.m_valid && u_if.m_ready) rx_q.push_back(u_if.m_data);
   end

   task automatic drive_bit(input logic b);
      io_rxd = b;
      repeat (CPB) @(posedge io_clock);
      #2;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      @(posedge io_clock);
      #2;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_SNIFF_PARITY_EN
      drive_bit((^d) ^ bad_par);
`endif
      drive_bit(stop_b);
   endtask

   task automatic test_reset();
      u_if.m_ready = 1'b0;
      repeat (4) @(negedge io_clock);
      n_checks++; if (u_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", u_if.m_valid); end
      n_checks++; if (u_if.m_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", u_if.m_data); end
      @(posedge io_clock); #2 io_reset = 1'b1;
      repeat (5) @(negedge io_clock);
      n_checks++; if (o_level !== 4'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", o_level); end
      n_checks++; if ({o_frame_err, o_parity_err, o_overflow} !== 3'b000) begin
         n_fail++; $display("FAIL rst_flags: got %b want 000", {o_frame_err, o_parity_err, o_overflow}); end
      n_checks++; if (u_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_after: got %b want 0", u_if.m_valid); end
   endtask

   task automatic test_basic();
      int n;
      u_if.m_ready = 1'b1;
      rx_q.delete();
      @(negedge io_clock); #1;
      n = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (n < 6000) begin
               @(negedge io_clock);
               n++;
               if (u_if.m_valid) break;
            end
         end
      join
      repeat (20) @(negedge io_clock);
      n_checks++; if (n !== FIRST_VALID) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", n, FIRST_VALID); end
      n_checks++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", rx_q.size()); end
      n_checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
      n_checks++; if ({o_frame_err, o_parity_err, o_overflow} !== 3'b000) begin
         n_fail++; $display("FAIL basic_flags: got %b want 000", {o_frame_err, o_parity_err, o_overflow}); end
   endtask

   task automatic test_glitch();
      rx_q.delete();
      @(posedge io_clock); #2 io_rxd = 1'b0;
      repeat (100) @(posedge io_clock);
      #2 io_rxd = 1'b1;
      repeat (1000) @(negedge io_clock);
      n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", rx_q.size()); end
      n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want %0d", dut.state, IDLE); end
      n_checks++; if (o_level !== 4'd0) begin n_fail++; $display("FAIL glitch_level: got %0d want 0", o_level); end
      n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr: got %b want 0", o_frame_err); end
   endtask

   task automatic test_frame_err();
      rx_q.delete();
      send_frame(8'h3C, 1'b0);
      repeat (2000) @(posedge io_clock);
      @(negedge io_clock);
      n_checks++; if (dut.state !== BREAK) begin n_fail++; $display("FAIL ferr_state: got %0d want %0d", dut.state, BREAK); end
      n_checks++; if (o_frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", o_frame_err); end
      n_checks++; if (rx_q.size() !== 0 || o_level !== 4'd0) begin
         n_fail++; $display("FAIL ferr_nobyte: got count %0d level %0d want 0/0", rx_q.size(), o_level); end
      @(posedge io_clock); #2 io_rxd = 1'b1;
      repeat (50) @(posedge io_clock);
      send_frame(8'h11, 1'b1);
      repeat (20) @(negedge io_clock);
      n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h11) begin
         n_fail++; $display("FAIL ferr_next: got count %0d want 1 byte 11", rx_q.size()); end
      n_checks++; if (o_frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b want 1", o_frame_err); end
      @(posedge io_clock); #2 i_clear = 1'b1;
      @(posedge io_clock); #2 i_clear = 1'b0;
      @(negedge io_clock);
      n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", o_frame_err); end
   endtask

   task automatic test_overflow();
      u_if.m_ready = 1'b0;
      rx_q.delete();
      for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b1);
      repeat (20) @(negedge io_clock);
      n_checks++; if (o_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", o_level); end
      n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
      n_checks++; if (u_if.m_valid !== 1'b1 || u_if.m_data !== 8'h00) begin
         n_fail++; $display("FAIL ovf_head: got valid %b data %h want 1/00", u_if.m_valid, u_if.m_data); end
      @(posedge io_clock); #2 u_if.m_ready = 1'b1;
      repeat (20) @(negedge io_clock);
      n_checks++; if (rx_q.size() !== 8) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 8", rx_q.size()); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (i >= rx_q.size() || rx_q[i] !== 8'(i)) begin
            n_fail++; $display("FAIL ovf_order[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(i));
         end
      end
      n_checks++; if (o_level !== 4'd0 || u_if.m_valid !== 1'b0) begin
         n_fail++; $display("FAIL ovf_empty: got level %0d valid %b want 0/0", o_level, u_if.m_valid); end
   endtask

   task automatic test_reset_mid();
      u_if.m_ready = 1'b0;
      rx_q.delete();
      send_frame(8'h77, 1'b1);
      repeat (5) @(negedge io_clock);
      n_checks++; if (o_level !== 4'd1) begin n_fail++; $display("FAIL rmid_pre_level: got %0d want 1", o_level); end
      @(posedge io_clock); #2;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      io_rxd = 1'b1;
      repeat (CPB / 2) @(posedge io_clock);
      #2 io_reset = 1'b0;
      repeat (3) @(negedge io_clock);
      n_checks++; if (u_if.m_valid !== 1'b0 || u_if.m_data !== 8'h00 || o_level !== 4'd0) begin
         n_fail++; $display("FAIL rmid_outputs: got valid %b data %h level %0d want 0/00/0", u_if.m_valid, u_if.m_data, o_level); end
      n_checks++; if ({o_frame_err, o_parity_err, o_overflow} !== 3'b000) begin
         n_fail++; $display("FAIL rmid_flags: got %b want 000", {o_frame_err, o_parity_err, o_overflow}); end
      n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d want %0d", dut.state, IDLE); end
      @(posedge io_clock); #2 io_reset = 1'b1;
      repeat (5 * CPB) @(posedge io_clock);
      @(negedge io_clock);
      n_checks++; if (o_level !== 4'd0) begin n_fail++; $display("FAIL rmid_partial: got level %0d want 0", o_level); end
      u_if.m_ready = 1'b1;
      send_frame(8'h5A, 1'b1);
      repeat (20) @(negedge io_clock);
      n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A) begin
         n_fail++; $display("FAIL rmid_after: got count %0d want 1 byte 5a", rx_q.size()); end
   endtask

`ifdef UART_SNIFF_PARITY_EN
   task automatic test_parity();
      u_if.m_ready = 1'b1;
      rx_q.delete();
      send_frame(8'h07, 1'b1);
      repeat (20) @(negedge io_clock);
      n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h07) begin
         n_fail++; $display("FAIL par_good: got count %0d want 1 byte 07", rx_q.size()); end
      n_checks++; if (o_parity_err !== 1'b0) begin n_fail++; $display("FAIL par_good_flag: got %b want 0", o_parity_err); end
      bad_par = 1'b1;
      send_frame(8'h07, 1'b1);
      bad_par = 1'b0;
      repeat (20) @(negedge io_clock);
      n_checks++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL par_bad_drop: got count %0d want 1", rx_q.size()); end
      n_checks++; if (o_parity_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_flag: got %b want 1", o_parity_err); end
   endtask
`endif

   initial begin
      u_if.m_ready = 1'b0;
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overflow();
      test_reset_mid();
`ifdef UART_SNIFF_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_sniff_rx.md
# uart_sniff_rx

Bench-side and on-chip UART receive stage that consumes the SoC's `io_uartStd_txd` line, deframes 8N1 (optionally 8E1) characters and delivers bytes through a valid/ready stream backed by a small FIFO. It sits directly downstream of the Carbon1 top-level UART transmitter. It is used as a synthesizable monitor in simulation benches and as a loopback checker on FPGA builds. It also flags framing, parity and overflow errors.

## Interface
- `CLKS_PER_BIT`, 434: `io_clock` cycles per UART bit (50 MHz / 115200); minimum 8.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, 2..64.

- `io_clock`  in  1  sole clock; all logic on its rising edge.
- `io_reset`  in  1  reset, asynchronous assert, active-low; release is synchronous to `io_clock` by external design.
- `io_rxd`  in  1  serial line (idle high), asynchronous to `io_clock`.
- `m_valid`  out  1  FIFO head byte available.
- `m_data`  out  8  FIFO head byte.
- `m_ready`  in  1  consumer accepts head when `m_valid & m_ready`.
- `o_level`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- `o_frame_err`  out  1  sticky: stop bit sampled low.
- `o_parity_err`  out  1  sticky: parity mismatch.
- `o_overflow`  out  1  sticky: byte dropped because FIFO full.
- `i_clear`  in  1  synchronous one-cycle clear of all three sticky flags.

## Operation
- `io_rxd` passes a 2-FF synchronizer (reset value 1); all decisions use the synchronized `rxs`.
- FSM states:
  - IDLE: on `rxs`==0, go to START and load the bit counter `cnt`=0.
  - START: at `cnt`==CLKS_PER_BIT/2−1 sample `rxs`. If it is 1 (glitch), return to IDLE. If it is 0, go to DATA with `cnt` reset.
  - DATA: sample at every `cnt`==CLKS_PER_BIT−1; shift LSB-first into an 8-bit shift register. After bit 7, go to PARITY if compiled in, else to STOP.
  - PARITY: one sample, checked against the XOR of the data bits (even parity).
  - STOP: one sample. On 1, push the byte (unless parity failed) and go to IDLE. On 0, set `o_frame_err`, drop the byte and go to BREAK.
  - BREAK: wait until `rxs`==1, then go to IDLE. A held-low line therefore yields exactly one frame error, not repeated frames.
- `cnt` width is $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT−1.
- FIFO: push is accepted if not full, or if full and a pop occurs in the same cycle. Otherwise the byte is dropped and `o_overflow` is set. Simultaneous push and pop on an empty FIFO writes normally; the byte is not bypassed.
- When `i_clear` and a new error event coincide, the flag ends set.
- Reset mid-frame: the FSM returns to IDLE, the FIFO empties, and the partial byte is discarded. After release, a line that is already low is treated as a start edge.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `o_level`=0, all error flags=0.
- Pin to `rxs`: 2 cycles.
- STOP sample edge: the FIFO write happens on that edge. `m_valid` is high and `o_level` is incremented from the next cycle.
- Pop: `m_data` shows the next entry in the cycle after the handshake. `m_valid` drops in that cycle if the FIFO becomes empty.
- Error flags rise on the cycle after the offending sample.
- Frame length, start edge to IDLE: 9.5 bit times (8N1), 10.5 (8E1).

## Configuration
- `UART_SNIFF_PARITY_EN`:
  - Defined: the PARITY state exists, even parity is checked, and a mismatching byte is dropped with `o_parity_err` set.
  - Undefined: there is no PARITY state and the frame is 8N1. `o_parity_err` is tied 0, so the port list is identical in both builds.

## Structure
- Package `uart_sniff_pkg`: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK), default `CLKS_PER_BIT`/`FIFO_DEPTH` constants, and a level-width function.
- Sub-module `uart_sniff_fifo`: a synchronous FIFO with push/pop/full/empty/level.
- Top level: synchronizer, FSM, counters and sticky flags.

## Test plan
- Send 0xA5 as 8N1 at 434 clk/bit with `m_ready`=1. Expect exactly one `m_valid` beat with `m_data`=0xA5, 1 cycle after the stop sample, and no error flags.
- Drive a 100-cycle low pulse on `io_rxd`. Expect no byte, FSM back in IDLE, and `o_level`=0.
- Send 0x3C with the stop bit low, then hold the line low for 2000 cycles. Expect `o_frame_err`=1 once, no byte, and a following 0x11 received correctly. Pulse `i_clear` and expect the flag at 0.
- With `m_ready`=0, send 0x00..0x08 (9 bytes). Expect `o_level`=8 and `o_overflow`=1. Then raise `m_ready` and expect 0x00..0x07 in order.
- Assert `io_reset` low during bit 4 of 0xFF. Expect all outputs at reset values and no byte. After release, 0x5A is received correctly.
- With `UART_SNIFF_PARITY_EN` defined, send 0x07 with parity bit 1 (correct). Expect the byte. Then send 0x07 with parity bit 0. Expect no byte and `o_parity_err`=1.
